// File: rtl/data_recover_control.sv
// ----------------------------------------------------------------------------
// data_recover_control
//
// Receive-side data controller. Ciphertext words from the channel are
// buffered in a small FIFO. The controller then drives the key generator
// through a 2-bit instruction and recovers each plaintext word as
// head ^ key_out[OUT_WIDTH-1:0]. The result is presented on a valid/ready
// output.
//
// Every word passes through this sequence:
//   IDLE -> GEN (instruction 01, wait for done, bounded by TIMEOUT)
//        -> OUT (plaintext held until plain_ready)
//        -> CONSUME (one cycle, instruction 10, FIFO pop, key_in <= y0)
//        -> IDLE
//
// When GEN times out, the sticky timeout_err flag is set and the controller
// returns to IDLE. The head word stays in the FIFO and is retried.
//
// rst_n asserts asynchronously. Its release is expected to be synchronous to
// clk; the reset synchroniser sits upstream of this block.
//
// Ports
//   clk, rst_n     clock, async active-low reset
//   cipher_valid   ciphertext word offered
//   cipher_in      ciphertext word (OUT_WIDTH)
//   cipher_ready   FIFO can accept a word (= !full)
//   done           key generator has key_out ready
//   key_out        current key word (DATA_WIDTH)
//   y0             generator state feedback (DATA_WIDTH)
//   key_in         seed/state returned to the generator (DATA_WIDTH)
//   instruction    00 hold, 01 generate, 10 consume
//   plain_out      recovered plaintext (OUT_WIDTH)
//   plain_valid    plain_out valid
//   plain_ready    downstream accepts plain_out
//   fifo_count     words currently buffered
//   timeout_err    sticky: done not seen within TIMEOUT GEN cycles
// ----------------------------------------------------------------------------
module data_recover_control #(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cipher_valid,
    input  logic [OUT_WIDTH-1:0]          cipher_in,
    output logic                          cipher_ready,
    input  logic                          done,
    input  logic [DATA_WIDTH-1:0]         key_out,
    input  logic [DATA_WIDTH-1:0]         y0,
    output logic [DATA_WIDTH-1:0]         key_in,
    output logic [1:0]                    instruction,
    output logic [OUT_WIDTH-1:0]          plain_out,
    output logic                          plain_valid,
    input  logic                          plain_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] INSTR_HOLD    = 2'b00;
    localparam logic [1:0] INSTR_GEN     = 2'b01;
    localparam logic [1:0] INSTR_CONSUME = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GEN     = 2'd1,
        ST_OUT     = 2'd2,
        ST_CONSUME = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [1:0]             instr_q, instr_d;
    logic [DATA_WIDTH-1:0]  key_in_q, key_in_d;
    logic [OUT_WIDTH-1:0]   plain_out_q, plain_out_d;
    logic                   plain_valid_q, plain_valid_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [TMR_W-1:0]       timer_q, timer_d;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];

    logic                   full;
    logic                   push;
    logic                   pop;
    logic [OUT_WIDTH-1:0]   head;

    // Only the low OUT_WIDTH key bits take part in the XOR. This reduction
    // keeps the upper bits formally consumed.
    logic                   unused_key_bits;
    assign unused_key_bits = ^key_out;

    // ------------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------------
    assign full         = (count_q == CNT_W'(FIFO_DEPTH));
    assign cipher_ready = !full;
    assign push         = cipher_valid && !full;
    assign head         = mem[rd_ptr_q];

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so that no path leaves a signal unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // The depth is a power of two, so the pointers wrap naturally.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array carries no reset. Its contents are meaningless
    // while count is zero, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cipher_in;
    end

    // ------------------------------------------------------------------------
    // Control FSM: next state and registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        plain_out_d   = plain_out_q;
        plain_valid_d = plain_valid_q;
        timeout_err_d = timeout_err_q;
        key_in_d      = key_in_q;
        pop           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_GEN;
            end
            ST_GEN: begin
                if (done) begin
                    plain_out_d   = head ^ key_out[OUT_WIDTH-1:0];
                    plain_valid_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_OUT;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    // The head word is left in the FIFO, so IDLE retries it.
                    timeout_err_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_OUT: begin
                if (plain_ready) begin
                    plain_valid_d = 1'b0;
                    state_d       = ST_CONSUME;
                end
            end
            ST_CONSUME: begin
                pop      = 1'b1;
                key_in_d = y0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The instruction register tracks the state being entered. It is
        // therefore valid throughout the cycle spent in that state.
        unique case (state_d)
            ST_GEN:     instr_d = INSTR_GEN;
            ST_CONSUME: instr_d = INSTR_CONSUME;
            default:    instr_d = INSTR_HOLD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together on the edge, with no ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= INSTR_HOLD;
            key_in_q      <= '0;
            plain_out_q   <= '0;
            plain_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
            timer_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            key_in_q      <= key_in_d;
            plain_out_q   <= plain_out_d;
            plain_valid_q <= plain_valid_d;
            timeout_err_q <= timeout_err_d;
            timer_q       <= timer_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    assign instruction = instr_q;
    assign key_in      = key_in_q;
    assign plain_out   = plain_out_q;
    assign plain_valid = plain_valid_q;
    assign timeout_err = timeout_err_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_data_recover_control.sv
// ----------------------------------------------------------------------------
// tb_data_recover_control
//
// Directed bench for data_recover_control. The DUT is built with TIMEOUT=8 so
// that the timeout path can be reached in a few cycles. Inputs change 1 time
// unit after the rising edge, and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_data_recover_control;

    localparam int DW = 12;
    localparam int OW = 8;

    logic          clk;
    logic          rst_n;
    logic          cipher_valid;
    logic [OW-1:0] cipher_in;
    logic          cipher_ready;
    logic          done;
    logic [DW-1:0] key_out;
    logic [DW-1:0] y0;
    logic [DW-1:0] key_in;
    logic [1:0]    instruction;
    logic [OW-1:0] plain_out;
    logic          plain_valid;
    logic          plain_ready;
    logic [2:0]    fifo_count;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    data_recover_control #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .FIFO_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cipher_valid(cipher_valid), .cipher_in(cipher_in), .cipher_ready(cipher_ready),
        .done(done), .key_out(key_out), .y0(y0), .key_in(key_in),
        .instruction(instruction),
        .plain_out(plain_out), .plain_valid(plain_valid), .plain_ready(plain_ready),
        .fifo_count(fifo_count), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        cipher_valid = 1'b0;
        cipher_in    = '0;
        done         = 1'b0;
        key_out      = '0;
        y0           = '0;
        plain_ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    // Waits, with a bound, for plain_valid. The caller decides what a miss means.
    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (plain_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        bit seen;
        apply_reset();
        checks++; if (instruction !== 2'b00) begin errors++; $display("FAIL rst_instr: got %0h expected 0", instruction); end
        checks++; if (plain_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", plain_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if (cipher_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b expected 1", cipher_ready); end

        // Push two words and let the first complete. This leaves plain_out
        // and key_in non-zero while the second word sits in GEN.
        done = 1'b1; key_out = 12'h03C; y0 = 12'h777;
        cipher_valid = 1'b1; cipher_in = 8'hA5; tick();
        cipher_in = 8'h11; tick();
        cipher_valid = 1'b0;
        wait_valid(seen);
        checks++; if (!seen || plain_out !== 8'h99) begin errors++; $display("FAIL rst_pre_plain: got %0h seen=%0b expected 99", plain_out, seen); end
        plain_ready = 1'b1; done = 1'b0;
        tick(); tick();
        plain_ready = 1'b0;
        tick();
        checks++; if (instruction !== 2'b01) begin errors++; $display("FAIL rst_pre_gen: got %0h expected 1", instruction); end

        // Assert reset between clock edges. The outputs must clear at once.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instruction !== 2'b00) begin errors++; $display("FAIL async_instr: got %0h expected 0", instruction); end
        checks++; if (key_in !== 12'h000) begin errors++; $display("FAIL async_key_in: got %0h expected 0", key_in); end
        checks++; if (plain_out !== 8'h00) begin errors++; $display("FAIL async_plain: got %0h expected 0", plain_out); end
        checks++; if (plain_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %0b expected 0", plain_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL async_count: got %0d expected 0", fifo_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL async_terr: got %0b expected 0", timeout_err); end
        @(negedge clk) rst_n = 1'b1;
        tick(); tick();
        checks++; if (instruction !== 2'b00) begin errors++; $display("FAIL post_rst_idle: got %0h expected 0", instruction); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_word();
        int pulses;
        apply_reset();
        done = 1'b1; key_out = 12'h03C; plain_ready = 1'b1; y0 = 12'h123;
        cipher_valid = 1'b1; cipher_in = 8'hA5;
        tick();                                   // push edge E
        cipher_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL sw_count1: got %0d expected 1", fifo_count); end
        tick();                                   // E+1: GEN
        checks++; if (instruction !== 2'b01 || plain_valid !== 1'b0) begin errors++; $display("FAIL sw_gen: got instr=%0h valid=%0b expected 1/0", instruction, plain_valid); end
        tick();                                   // E+2: OUT
        checks++; if (plain_valid !== 1'b1) begin errors++; $display("FAIL sw_valid: got %0b expected 1", plain_valid); end
        checks++; if (plain_out !== 8'h99) begin errors++; $display("FAIL sw_plain: got %0h expected 99", plain_out); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (instruction === 2'b10) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL sw_consume_pulses: got %0d expected 1", pulses); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL sw_count0: got %0d expected 0", fifo_count); end
        checks++; if (key_in !== 12'h123) begin errors++; $display("FAIL sw_key_in: got %0h expected 123", key_in); end
        checks++; if (plain_valid !== 1'b0) begin errors++; $display("FAIL sw_valid_drop: got %0b expected 0", plain_valid); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        bit seen;
        int pulses;
        apply_reset();
        done = 1'b1; key_out = 12'h0F0; plain_ready = 1'b0;
        cipher_valid = 1'b1; cipher_in = 8'h12; tick();
        cipher_valid = 1'b0;
        wait_valid(seen);
        checks++; if (!seen || plain_out !== 8'hE2) begin errors++; $display("FAIL bp_plain: got %0h seen=%0b expected e2", plain_out, seen); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (plain_valid !== 1'b1 || plain_out !== 8'hE2 || instruction !== 2'b00 || fifo_count !== 3'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%0b plain=%0h instr=%0h count=%0d expected 1/e2/0/1",
                         i, plain_valid, plain_out, instruction, fifo_count);
            end
        end
        plain_ready = 1'b1;
        tick();
        checks++; if (instruction !== 2'b10 || plain_valid !== 1'b0) begin errors++; $display("FAIL bp_consume: got instr=%0h valid=%0b expected 2/0", instruction, plain_valid); end
        tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL bp_count: got %0d expected 0", fifo_count); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (instruction === 2'b10) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL bp_extra_consume: got %0d expected 0", pulses); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_full_fifo();
        bit seen;
        logic [7:0] words [5];
        logic [7:0] expd  [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        expd  = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
        apply_reset();
        done = 1'b0; plain_ready = 1'b1;
        cipher_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cipher_in = words[i];
            tick();
            checks++;
            if (fifo_count !== ((i < 4) ? 3'(i + 1) : 3'd4) || cipher_ready !== (i < 3)) begin
                errors++;
                $display("FAIL full_push[%0d]: got count=%0d ready=%0b", i, fifo_count, cipher_ready);
            end
        end
        cipher_valid = 1'b0;
        key_out = 12'h0FF; done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(seen);
            checks++;
            if (!seen || plain_out !== expd[k]) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %0h seen=%0b expected %0h", k, plain_out, seen, expd[k]);
            end
            tick();
        end
        repeat (6) tick();
        checks++; if (fifo_count !== 3'd0 || plain_valid !== 1'b0) begin errors++; $display("FAIL full_dropped: got count=%0d valid=%0b expected 0/0", fifo_count, plain_valid); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL full_terr: got %0b expected 0", timeout_err); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_timeout();
        bit seen;
        apply_reset();
        done = 1'b0; plain_ready = 1'b1;
        cipher_valid = 1'b1; cipher_in = 8'h5C; tick();   // push edge E
        cipher_valid = 1'b0;
        tick();                                            // E+1: GEN, timer 0
        checks++; if (instruction !== 2'b01) begin errors++; $display("FAIL to_gen: got %0h expected 1", instruction); end
        repeat (7) tick();                                 // E+8
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %0b expected 0", timeout_err); end
        tick();                                            // E+9: eighth GEN cycle ends
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b expected 1", timeout_err); end
        checks++; if (instruction !== 2'b00 || fifo_count !== 3'd1) begin errors++; $display("FAIL to_idle: got instr=%0h count=%0d expected 0/1", instruction, fifo_count); end
        key_out = 12'h3C3; done = 1'b1;
        wait_valid(seen);
        checks++; if (!seen || plain_out !== 8'h9F) begin errors++; $display("FAIL to_retry: got %0h seen=%0b expected 9f", plain_out, seen); end
        tick(); tick();
        checks++; if (fifo_count !== 3'd0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got count=%0d terr=%0b expected 0/1", fifo_count, timeout_err); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        bit seen;
        apply_reset();
        done = 1'b0; plain_ready = 1'b0; key_out = 12'h000;
        cipher_valid = 1'b1; cipher_in = 8'h01; tick();
        cipher_in = 8'h02; tick();
        cipher_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count2: got %0d expected 2", fifo_count); end
        done = 1'b1;
        wait_valid(seen);
        checks++; if (!seen || plain_out !== 8'h01) begin errors++; $display("FAIL b2b_first: got %0h seen=%0b expected 01", plain_out, seen); end
        y0 = 12'h5A3; plain_ready = 1'b1;
        tick();                                            // now in CONSUME
        checks++; if (instruction !== 2'b10 || fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_consume: got instr=%0h count=%0d expected 2/2", instruction, fifo_count); end
        cipher_valid = 1'b1; cipher_in = 8'h03;
        tick();                                            // push and pop on the same edge
        cipher_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL b2b_count_same: got %0d expected 2", fifo_count); end
        checks++; if (key_in !== 12'h5A3) begin errors++; $display("FAIL b2b_key_in: got %0h expected 5a3", key_in); end
        wait_valid(seen);
        checks++; if (!seen || plain_out !== 8'h02) begin errors++; $display("FAIL b2b_second: got %0h seen=%0b expected 02", plain_out, seen); end
        tick();
        wait_valid(seen);
        checks++; if (!seen || plain_out !== 8'h03) begin errors++; $display("FAIL b2b_third: got %0h seen=%0b expected 03", plain_out, seen); end
        tick(); tick();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_count0: got %0d expected 0", fifo_count); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        rst_n        = 1'b0;
        cipher_valid = 1'b0;
        cipher_in    = '0;
        done         = 1'b0;
        key_out      = '0;
        y0           = '0;
        plain_ready  = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_full_fifo();
        test_timeout();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
